// File: rtl/saturating_accumulator.sv
// rtl/saturating_accumulator.sv - multi-channel time-multiplexed saturating accumulator
//
// Purpose: each accepted input beat is added to (or subtracted from) the running
// sum of its channel; the result is clipped to [satn, satp], stored, and emitted
// on a single-entry registered output stream with one cycle of latency.
//
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-high reset
//   data_in, data_in_dest             signed sample and its target channel
//   data_in_valid, data_in_ready      input handshake (ready is combinational)
//   subtract, load                    per-beat operation modifiers
//   satp, satn                        signed saturation window (quasi-static)
//   data_out, data_out_dest           saturated accumulator value and its channel
//   data_out_valid, data_out_ready    output handshake
//   sat_flags, sat_flags_clear        sticky per-channel clip indicators and their clear

module saturating_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int N_CHANNELS = 4,
    parameter int DEST_WIDTH = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic        [DEST_WIDTH-1:0] data_in_dest,
    input  logic                         data_in_valid,
    output logic                         data_in_ready,
    input  logic                         subtract,
    input  logic                         load,
    input  logic signed [DATA_WIDTH-1:0] satp,
    input  logic signed [DATA_WIDTH-1:0] satn,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic        [DEST_WIDTH-1:0] data_out_dest,
    output logic                         data_out_valid,
    input  logic                         data_out_ready,
    output logic        [N_CHANNELS-1:0] sat_flags,
    input  logic                         sat_flags_clear
);

    localparam int IDX_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

    logic signed [DATA_WIDTH-1:0] acc [N_CHANNELS];

    logic                         accept;
    logic                         dest_ok;
    logic                         write;
    logic        [IDX_W-1:0]      idx;
    logic signed [DATA_WIDTH:0]   base;
    logic signed [DATA_WIDTH:0]   operand;
    logic signed [DATA_WIDTH:0]   sum;
    logic signed [DATA_WIDTH:0]   satp_x;
    logic signed [DATA_WIDTH:0]   satn_x;
    logic                         clip_hi;
    logic                         clip_lo;
    logic signed [DATA_WIDTH-1:0] result;
    logic        [N_CHANNELS-1:0] set_vec;

    // The output register is the only buffer, so new input is possible
    // exactly when it is empty or being drained this cycle.
    assign data_in_ready = !data_out_valid || data_out_ready;
    assign accept        = data_in_valid && data_in_ready;
    assign dest_ok       = (32'(data_in_dest) < N_CHANNELS);
    assign write         = accept && dest_ok;

    always_comb begin
        idx     = '0;
        if (dest_ok) begin
            idx = IDX_W'(data_in_dest);
        end
        // One guard bit keeps the raw sum exact, including subtracting the
        // most negative sample, so clipping sees the true value.
        base    = load ? '0 : {acc[idx][DATA_WIDTH-1], acc[idx]};
        operand = {data_in[DATA_WIDTH-1], data_in};
        sum     = subtract ? (base - operand) : (base + operand);
        satp_x  = {satp[DATA_WIDTH-1], satp};
        satn_x  = {satn[DATA_WIDTH-1], satn};
        clip_hi = (sum > satp_x);
        clip_lo = (sum < satn_x);
        // Upper limit has priority, which defines behaviour for satp < satn.
        if (clip_hi) begin
            result = satp;
        end else if (clip_lo) begin
            result = satn;
        end else begin
            result = sum[DATA_WIDTH-1:0];
        end
        set_vec = '0;
        if (write) begin
            set_vec[idx] = clip_hi || clip_lo;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                acc[i] <= '0;
            end
            data_out       <= '0;
            data_out_dest  <= '0;
            data_out_valid <= 1'b0;
            sat_flags      <= '0;
        end else begin
            if (write) begin
                acc[idx]       <= result;
                data_out       <= result;
                data_out_dest  <= data_in_dest;
                data_out_valid <= 1'b1;
            end else if (data_out_ready) begin
                data_out_valid <= 1'b0;
            end
            // A flag being set this cycle survives a simultaneous clear.
            sat_flags <= (sat_flags_clear ? '0 : sat_flags) | set_vec;
        end
    end

endmodule

// File: tb/tb_saturating_accumulator.sv
// tb/tb_saturating_accumulator.sv - self-checking bench for saturating_accumulator

module tb_saturating_accumulator;

    localparam int DW  = 16;
    localparam int NC  = 4;
    localparam int DSW = 3;

    logic                 clock = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] data_in;
    logic [DSW-1:0]       data_in_dest;
    logic                 data_in_valid;
    logic                 data_in_ready;
    logic                 subtract;
    logic                 load;
    logic signed [DW-1:0] satp;
    logic signed [DW-1:0] satn;
    logic signed [DW-1:0] data_out;
    logic [DSW-1:0]       data_out_dest;
    logic                 data_out_valid;
    logic                 data_out_ready;
    logic [NC-1:0]        sat_flags;
    logic                 sat_flags_clear;

    always #5 clock = ~clock;

    saturating_accumulator #(
        .DATA_WIDTH(DW),
        .N_CHANNELS(NC),
        .DEST_WIDTH(DSW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .data_in(data_in),
        .data_in_dest(data_in_dest),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .subtract(subtract),
        .load(load),
        .satp(satp),
        .satn(satn),
        .data_out(data_out),
        .data_out_dest(data_out_dest),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .sat_flags(sat_flags),
        .sat_flags_clear(sat_flags_clear)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integers, clamped by the window rules.
    int            acc_m [NC];
    bit [NC-1:0]   flags_m;
    int            satp_m;
    int            satn_m;
    int            exp_out;
    int            exp_dest;

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) acc_m[i] = 0;
        flags_m  = '0;
        exp_out  = 0;
        exp_dest = 0;
    endfunction

    function automatic int model_beat(int dest, int val, bit sub, bit ld, bit clr);
        longint b;
        longint s;
        int     r;
        bit     clip;
        b    = ld ? 0 : acc_m[dest];
        s    = sub ? (b - val) : (b + val);
        clip = 1'b1;
        if (s > satp_m)      r = satp_m;
        else if (s < satn_m) r = satn_m;
        else begin
            r    = int'(s);
            clip = 1'b0;
        end
        acc_m[dest] = r;
        if (clr) flags_m = '0;
        if (clip) flags_m[dest] = 1'b1;
        exp_out  = r;
        exp_dest = dest;
        return r;
    endfunction

    task automatic set_limits(input int p, input int n);
        satp   = p[DW-1:0];
        satn   = n[DW-1:0];
        satp_m = p;
        satn_m = n;
    endtask

    task automatic drive_beat(input int dest, input int val, input bit sub, input bit ld);
        data_in_dest  = DSW'(dest);
        data_in       = val[DW-1:0];
        subtract      = sub;
        load          = ld;
        data_in_valid = 1'b1;
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        data_in_valid = 1'b1;
        data_in       = 16'sd123;
        data_in_dest  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset         = 1'b0;
        data_in_valid = 1'b0;
        model_reset();
        #1;
        n_checks++; if (data_out !== 16'sd0) begin n_fail++; $display("FAIL reset_data_out got=%0d exp=0", data_out); end
        n_checks++; if (data_out_dest !== 3'd0) begin n_fail++; $display("FAIL reset_dest got=%0d exp=0", data_out_dest); end
        n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", data_out_valid); end
        n_checks++; if (sat_flags !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", sat_flags); end
        n_checks++; if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", data_in_ready); end
    endtask

    task automatic test_saturate_add();
        int e;
        logic [DW-1:0] e16;
        set_limits(1000, -1000);
        for (int i = 0; i < 3; i++) begin
            e = model_beat(0, 400, 1'b0, 1'b0, 1'b0);
            drive_beat(0, 400, 1'b0, 1'b0);
            e16 = e[DW-1:0];
            n_checks++; if (data_out !== e16) begin n_fail++; $display("FAIL add_out beat=%0d got=%0d exp=%0d", i, data_out, e); end
            n_checks++; if (data_out_valid !== 1'b1 || data_out_dest !== 3'd0) begin n_fail++; $display("FAIL add_valid_dest beat=%0d got=%0b/%0d exp=1/0", i, data_out_valid, data_out_dest); end
        end
        n_checks++; if (sat_flags[0] !== 1'b1) begin n_fail++; $display("FAIL add_flag0 got=%0b exp=1", sat_flags[0]); end
    endtask

    task automatic test_subtract();
        int e;
        logic [DW-1:0] e16;
        for (int i = 0; i < 2; i++) begin
            e = model_beat(1, 600, 1'b1, 1'b0, 1'b0);
            drive_beat(1, 600, 1'b1, 1'b0);
            e16 = e[DW-1:0];
            n_checks++; if (data_out !== e16 || data_out_dest !== 3'd1) begin n_fail++; $display("FAIL sub_out beat=%0d got=%0d@%0d exp=%0d@1", i, data_out, data_out_dest, e); end
        end
        n_checks++; if (sat_flags !== flags_m) begin n_fail++; $display("FAIL sub_flags got=%b exp=%b", sat_flags, flags_m); end
        e = model_beat(0, 0, 1'b0, 1'b0, 1'b0);
        drive_beat(0, 0, 1'b0, 1'b0);
        e16 = e[DW-1:0];
        n_checks++; if (data_out !== e16) begin n_fail++; $display("FAIL sub_ch0_untouched got=%0d exp=%0d", data_out, e); end
    endtask

    task automatic test_wrap();
        int e;
        logic [DW-1:0] e16;
        set_limits(32767, -32768);
        void'(model_beat(2, 32000, 1'b0, 1'b1, 1'b0));
        drive_beat(2, 32000, 1'b0, 1'b1);
        e = model_beat(2, 1000, 1'b0, 1'b0, 1'b0);
        drive_beat(2, 1000, 1'b0, 1'b0);
        e16 = e[DW-1:0];
        n_checks++; if (data_out !== e16) begin n_fail++; $display("FAIL wrap_add got=%0d exp=%0d", data_out, e); end
        e = model_beat(3, -32768, 1'b1, 1'b1, 1'b0);
        drive_beat(3, -32768, 1'b1, 1'b1);
        e16 = e[DW-1:0];
        n_checks++; if (data_out !== e16) begin n_fail++; $display("FAIL wrap_sub_min got=%0d exp=%0d", data_out, e); end
        n_checks++; if (sat_flags !== flags_m) begin n_fail++; $display("FAIL wrap_flags got=%b exp=%b", sat_flags, flags_m); end
        set_limits(-50, 50);
        e = model_beat(2, 0, 1'b0, 1'b1, 1'b0);
        drive_beat(2, 0, 1'b0, 1'b1);
        e16 = e[DW-1:0];
        n_checks++; if (data_out !== e16) begin n_fail++; $display("FAIL inverted_limits got=%0d exp=%0d", data_out, e); end
        set_limits(32767, -32768);
    endtask

    task automatic test_backpressure();
        int            ea;
        int            eb;
        logic [DW-1:0] e16;
        ea = model_beat(0, 10, 1'b0, 1'b1, 1'b0);
        drive_beat(0, 10, 1'b0, 1'b1);
        data_out_ready = 1'b0;
        data_in_dest   = 3'd0;
        data_in        = 16'sd20;
        subtract       = 1'b0;
        load           = 1'b0;
        data_in_valid  = 1'b1;
        #1;
        e16 = ea[DW-1:0];
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (data_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%0b exp=0", i, data_in_ready); end
            n_checks++; if (data_out !== e16 || data_out_valid !== 1'b1 || data_out_dest !== 3'd0) begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%0d/%0b exp=%0d/1", i, data_out, data_out_valid, ea); end
            @(posedge clock);
            #1;
        end
        data_out_ready = 1'b1;
        eb = model_beat(0, 20, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
        e16 = eb[DW-1:0];
        n_checks++; if (data_out !== e16 || data_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume got=%0d/%0b exp=%0d/1", data_out, data_out_valid, eb); end
        @(posedge clock);
        #1;
        n_checks++; if (data_out_valid !== 1'b0 || data_out !== e16) begin n_fail++; $display("FAIL bp_no_dup got=%0d/%0b exp=%0d/0", data_out, data_out_valid, eb); end
    endtask

    task automatic test_interleave();
        int            ds [4] = '{0, 1, 0, 1};
        int            vs [4] = '{100, 200, 5, 50};
        bit            ls [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int            e;
        logic [DW-1:0] e16;
        for (int i = 0; i < 4; i++) begin
            e = model_beat(ds[i], vs[i], 1'b0, ls[i], 1'b0);
            drive_beat(ds[i], vs[i], 1'b0, ls[i]);
            e16 = e[DW-1:0];
            n_checks++; if (data_out !== e16 || data_out_dest !== DSW'(ds[i]) || data_out_valid !== 1'b1) begin n_fail++; $display("FAIL interleave beat=%0d got=%0d@%0d exp=%0d@%0d", i, data_out, data_out_dest, e, ds[i]); end
        end
        drive_beat(7, 999, 1'b0, 1'b0);
        e16 = exp_out[DW-1:0];
        n_checks++; if (data_out_valid !== 1'b0) begin n_fail++; $display("FAIL bad_dest_valid got=%0b exp=0", data_out_valid); end
        n_checks++; if (data_out !== e16 || data_out_dest !== DSW'(exp_dest)) begin n_fail++; $display("FAIL bad_dest_hold got=%0d@%0d exp=%0d@%0d", data_out, data_out_dest, exp_out, exp_dest); end
        n_checks++; if (sat_flags !== flags_m) begin n_fail++; $display("FAIL bad_dest_flags got=%b exp=%b", sat_flags, flags_m); end
    endtask

    task automatic test_flag_clear();
        int            e;
        logic [DW-1:0] e16;
        set_limits(100, -100);
        sat_flags_clear = 1'b1;
        e = model_beat(1, 500, 1'b0, 1'b1, 1'b1);
        drive_beat(1, 500, 1'b0, 1'b1);
        sat_flags_clear = 1'b0;
        e16 = e[DW-1:0];
        n_checks++; if (data_out !== e16) begin n_fail++; $display("FAIL clr_out got=%0d exp=%0d", data_out, e); end
        n_checks++; if (sat_flags !== flags_m) begin n_fail++; $display("FAIL clr_set_wins got=%b exp=%b", sat_flags, flags_m); end
        sat_flags_clear = 1'b1;
        flags_m = '0;
        @(posedge clock);
        #1;
        sat_flags_clear = 1'b0;
        n_checks++; if (sat_flags !== flags_m) begin n_fail++; $display("FAIL clr_only got=%b exp=%b", sat_flags, flags_m); end
    endtask

    task automatic test_reset_midstream();
        int            e;
        logic [DW-1:0] e16;
        void'(model_beat(0, 500, 1'b0, 1'b1, 1'b0));
        drive_beat(0, 500, 1'b0, 1'b1);
        data_in_dest  = 3'd1;
        data_in       = 16'sd3;
        subtract      = 1'b0;
        load          = 1'b0;
        data_in_valid = 1'b1;
        reset         = 1'b1;
        @(posedge clock);
        #1;
        reset         = 1'b0;
        data_in_valid = 1'b0;
        model_reset();
        n_checks++; if (data_out_valid !== 1'b0 || data_out !== 16'sd0 || data_out_dest !== 3'd0) begin n_fail++; $display("FAIL midrst_out got=%0d@%0d/%0b exp=0@0/0", data_out, data_out_dest, data_out_valid); end
        n_checks++; if (sat_flags !== 4'b0) begin n_fail++; $display("FAIL midrst_flags got=%b exp=0000", sat_flags); end
        n_checks++; if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%0b exp=1", data_in_ready); end
        e = model_beat(1, 7, 1'b0, 1'b0, 1'b0);
        drive_beat(1, 7, 1'b0, 1'b0);
        e16 = e[DW-1:0];
        n_checks++; if (data_out !== e16) begin n_fail++; $display("FAIL midrst_restart got=%0d exp=%0d", data_out, e); end
    endtask

    task automatic test_random();
        bit            pend_m;
        bit            ready_m;
        bit            v;
        bit            ordy;
        bit            sub;
        bit            ld;
        bit            clr;
        int            d;
        int            val;
        logic [DW-1:0] r;
        logic [DW-1:0] e16;
        data_out_ready = 1'b1;
        data_in_valid  = 1'b0;
        @(posedge clock);
        #1;
        pend_m = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 50 == 0) begin
                if (cyc == 0) set_limits(32767, -32768);
                else set_limits($urandom_range(0, 40000) - 20000, $urandom_range(0, 40000) - 20000);
            end
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            sub  = $urandom_range(0, 1);
            ld   = ($urandom_range(0, 7) == 0);
            clr  = ($urandom_range(0, 15) == 0);
            d    = $urandom_range(0, 7);
            r    = DW'($urandom);
            val  = int'($signed(r));
            data_in_dest    = DSW'(d);
            data_in         = r;
            subtract        = sub;
            load            = ld;
            data_in_valid   = v;
            data_out_ready  = ordy;
            sat_flags_clear = clr;
            #1;
            ready_m = !pend_m || ordy;
            n_checks++; if (data_in_ready !== ready_m) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, data_in_ready, ready_m); end
            @(posedge clock);
            if (v && ready_m && d < NC) begin
                void'(model_beat(d, val, sub, ld, clr));
                pend_m = 1'b1;
            end else begin
                if (clr) flags_m = '0;
                if (ordy) pend_m = 1'b0;
            end
            #1;
            e16 = exp_out[DW-1:0];
            n_checks++; if (data_out_valid !== pend_m) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, data_out_valid, pend_m); end
            n_checks++; if (data_out !== e16 || data_out_dest !== DSW'(exp_dest)) begin n_fail++; $display("FAIL rnd_out cyc=%0d got=%0d@%0d exp=%0d@%0d", cyc, data_out, data_out_dest, exp_out, exp_dest); end
            n_checks++; if (sat_flags !== flags_m) begin n_fail++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc, sat_flags, flags_m); end
        end
        data_in_valid   = 1'b0;
        sat_flags_clear = 1'b0;
        data_out_ready  = 1'b1;
    endtask

    initial begin
        reset           = 1'b1;
        data_in         = '0;
        data_in_dest    = '0;
        data_in_valid   = 1'b0;
        subtract        = 1'b0;
        load            = 1'b0;
        data_out_ready  = 1'b1;
        sat_flags_clear = 1'b0;
        set_limits(32767, -32768);
        model_reset();
        @(negedge clock);
        test_reset();
        test_saturate_add();
        test_subtract();
        test_wrap();
        test_backpressure();
        test_interleave();
        test_flag_clear();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
